// File: rtl/me_control.sv
// Full-search motion estimator sequencer and best-match tracker.
// Sweeps 16 candidate rows, drives memory addresses and PE control, keeps min SAD.
module me_control #(
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       completed,
    output logic       busy,
    output logic [7:0] AddressR,
    output logic [9:0] AddressS1,
    output logic [9:0] AddressS2,
    output logic       pe_clear,
    output logic       pe_en,
    output logic [3:0] pe_sel,
    input  logic [7:0] pe_dist,
    output logic [7:0] BestDist,
    output logic [3:0] motionX,
    output logic [3:0] motionY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_CMP,
        S_DONE
    } state_t;

    localparam logic [3:0] LP_DLAST = 4'(DRAIN_CYC - 1);

    state_t     r_state;
    logic [3:0] r_dy;
    logic [3:0] r_r;
    logic [3:0] r_c;
    logic [3:0] r_drain;
    logic [4:0] r_k;

    logic       r_completed;
    logic       r_busy;
    logic [7:0] r_addr_r;
    logic [9:0] r_addr_s1;
    logic [9:0] r_addr_s2;
    logic       r_pe_clear;
    logic       r_pe_en;
    logic [3:0] r_pe_sel;
    logic [7:0] r_best;
    logic [3:0] r_mx;
    logic [3:0] r_my;

    logic [3:0] w_c_nxt;
    logic [3:0] w_r_nxt;
    logic       w_last_px;
    logic [3:0] w_ar;
    logic [3:0] w_ac;
    logic [4:0] w_row;
    logic [7:0] w_addr_r;
    logic [9:0] w_addr_s1;
    logic [9:0] w_addr_s2;
    logic [4:0] w_k_nxt;
    logic [3:0] w_dx;
    logic       w_better;

    assign completed = r_completed;
    assign busy      = r_busy;
    assign AddressR  = r_addr_r;
    assign AddressS1 = r_addr_s1;
    assign AddressS2 = r_addr_s2;
    assign pe_clear  = r_pe_clear;
    assign pe_en     = r_pe_en;
    assign pe_sel    = r_pe_sel;
    assign BestDist  = r_best;
    assign motionX   = r_mx;
    assign motionY   = r_my;

    // Next pixel position in raster order inside the 16x16 block.
    assign w_c_nxt   = r_c + 4'd1;
    assign w_r_nxt   = (r_c == 4'd15) ? r_r + 4'd1 : r_r;
    assign w_last_px = (r_r == 4'd15) && (r_c == 4'd15);

    // Position whose addresses are presented on the coming edge;
    // leaving CLEAR always presents pixel (0,0).
    assign w_ar = (r_state == S_CLEAR) ? 4'd0 : w_r_nxt;
    assign w_ac = (r_state == S_CLEAR) ? 4'd0 : w_c_nxt;

    // (dy+r)*32 + c and +16: the row sum forms the upper bits directly.
    assign w_row     = {1'b0, r_dy} + {1'b0, w_ar};
    assign w_addr_r  = {w_ar, w_ac};
    assign w_addr_s1 = {w_row, 1'b0, w_ac};
    assign w_addr_s2 = {w_row, 1'b1, w_ac};

    // Compare step bookkeeping: k counts 0..16, sample k is for dx=k-1.
    assign w_k_nxt  = r_k + 5'd1;
    assign w_dx     = r_k[3:0] - 4'd1;
    assign w_better = (pe_dist < r_best);

    // Sequencer: state, counters and every registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_dy        <= 4'd0;
            r_r         <= 4'd0;
            r_c         <= 4'd0;
            r_drain     <= 4'd0;
            r_k         <= 5'd0;
            r_completed <= 1'b0;
            r_busy      <= 1'b0;
            r_addr_r    <= 8'd0;
            r_addr_s1   <= 10'd0;
            r_addr_s2   <= 10'd0;
            r_pe_clear  <= 1'b0;
            r_pe_en     <= 1'b0;
            r_pe_sel    <= 4'd0;
            r_best      <= 8'hFF;
            r_mx        <= 4'd0;
            r_my        <= 4'd0;
        end else begin
            r_pe_clear <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_dy        <= 4'd0;
                        r_best      <= 8'hFF;
                        r_mx        <= 4'd0;
                        r_my        <= 4'd0;
                        r_completed <= 1'b0;
                        r_busy      <= 1'b1;
                        r_pe_clear  <= 1'b1;
                        r_state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_r       <= 4'd0;
                    r_c       <= 4'd0;
                    r_pe_en   <= 1'b1;
                    r_addr_r  <= w_addr_r;
                    r_addr_s1 <= w_addr_s1;
                    r_addr_s2 <= w_addr_s2;
                    r_state   <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (w_last_px) begin
                        r_r       <= 4'd0;
                        r_c       <= 4'd0;
                        r_pe_en   <= 1'b0;
                        r_addr_r  <= 8'd0;
                        r_addr_s1 <= 10'd0;
                        r_addr_s2 <= 10'd0;
                        r_drain   <= 4'd0;
                        r_state   <= S_DRAIN;
                    end else begin
                        r_r       <= w_r_nxt;
                        r_c       <= w_c_nxt;
                        r_addr_r  <= w_addr_r;
                        r_addr_s1 <= w_addr_s1;
                        r_addr_s2 <= w_addr_s2;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == LP_DLAST) begin
                        r_k      <= 5'd0;
                        r_pe_sel <= 4'd0;
                        r_state  <= S_CMP;
                    end else begin
                        r_drain <= r_drain + 4'd1;
                    end
                end
                S_CMP: begin
                    if ((r_k != 5'd0) && w_better) begin
                        r_best <= pe_dist;
                        r_mx   <= w_dx;
                        r_my   <= r_dy;
                    end
                    if (r_k[4]) begin
                        r_pe_sel <= 4'd0;
                        if (r_dy == 4'd15) begin
                            r_completed <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= S_DONE;
                        end else begin
                            r_dy       <= r_dy + 4'd1;
                            r_pe_clear <= 1'b1;
                            r_state    <= S_CLEAR;
                        end
                    end else begin
                        r_k      <= w_k_nxt;
                        r_pe_sel <= w_k_nxt[4] ? 4'd0 : w_k_nxt[3:0];
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_me_control.sv
// Self-checking bench for me_control.
// Cycle-schedule model plus candidate-order best-match model.
module tb_me_control;

    localparam int D    = 2;
    localparam int P    = 274 + D;
    localparam int TEND = 16 * P;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       completed;
    logic       busy;
    logic [7:0] AddressR;
    logic [9:0] AddressS1;
    logic [9:0] AddressS2;
    logic       pe_clear;
    logic       pe_en;
    logic [3:0] pe_sel;
    logic [7:0] pe_dist;
    logic [7:0] BestDist;
    logic [3:0] motionX;
    logic [3:0] motionY;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit run = 1'b0;
    int t = 0;

    logic [7:0] sad [0:255];
    int bd [0:256];
    int bx [0:256];
    int by [0:256];

    int e_clr, e_en, e_ar, e_s1, e_s2, e_sel, e_busy, e_cmp, e_n;
    int m_row, m_off, m_idx, m_k;

    int cyc, n_en, n_clr, s1_first, s1_last, s2_last;

    always #5 clk = ~clk;

    me_control #(.DRAIN_CYC(D)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .completed(completed),
        .busy(busy),
        .AddressR(AddressR),
        .AddressS1(AddressS1),
        .AddressS2(AddressS2),
        .pe_clear(pe_clear),
        .pe_en(pe_en),
        .pe_sel(pe_sel),
        .pe_dist(pe_dist),
        .BestDist(BestDist),
        .motionX(motionX),
        .motionY(motionY)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int row_of(input int tt);
        int rr;
        rr = (tt < 1) ? 0 : (tt - 1) / P;
        if (rr > 15) rr = 15;
        return rr;
    endfunction

    // Best match after the first n candidates in dy-major, dx-minor order.
    task automatic build_model();
        int best, xb, yb;
        best = 255; xb = 0; yb = 0;
        bd[0] = best; bx[0] = xb; by[0] = yb;
        for (int n = 0; n < 256; n++) begin
            if (int'(sad[n]) < best) begin
                best = int'(sad[n]);
                xb = n % 16;
                yb = n / 16;
            end
            bd[n+1] = best; bx[n+1] = xb; by[n+1] = yb;
        end
    endtask

    task automatic fill(input int v);
        for (int n = 0; n < 256; n++) sad[n] = 8'(v);
    endtask

    // Bench notion of time since the accepted start.
    always @(posedge clk) begin
        if (reset) begin
            run <= 1'b0;
            t   <= 0;
        end else if (start && (!run || t > TEND)) begin
            run <= 1'b1;
            t   <= 1;
        end else if (run) begin
            t <= t + 1;
        end
    end

    // PE array stand-in: one-cycle readout of the selected distance.
    always @(posedge clk) begin
        pe_dist <= sad[row_of(t) * 16 + int'(pe_sel)];
    end

    // Every-cycle comparison against the schedule model.
    always @(negedge clk) begin
        if (chk_en) begin
            e_clr = 0; e_en = 0; e_ar = 0; e_s1 = 0; e_s2 = 0;
            e_sel = 0; e_busy = 0; e_cmp = 0; e_n = 0;
            if (run && t <= TEND) begin
                m_row  = (t - 1) / P;
                m_off  = (t - 1) % P;
                e_busy = 1;
                e_n    = m_row * 16;
                if (m_off == 0) begin
                    e_clr = 1;
                end else if (m_off <= 256) begin
                    m_idx = m_off - 1;
                    e_en  = 1;
                    e_ar  = m_idx;
                    e_s1  = (m_row + m_idx / 16) * 32 + m_idx % 16;
                    e_s2  = e_s1 + 16;
                end else if (m_off >= 257 + D) begin
                    m_k = m_off - 257 - D;
                    if (m_k <= 15) e_sel = m_k;
                    if (m_k >= 1) e_n = m_row * 16 + m_k - 1;
                end
            end else if (run) begin
                e_cmp = 1;
                e_n   = 256;
            end
            chk("pe_clear", int'(pe_clear), e_clr);
            chk("pe_en", int'(pe_en), e_en);
            chk("AddressR", int'(AddressR), e_ar);
            chk("AddressS1", int'(AddressS1), e_s1);
            chk("AddressS2", int'(AddressS2), e_s2);
            chk("pe_sel", int'(pe_sel), e_sel);
            chk("busy", int'(busy), e_busy);
            chk("completed", int'(completed), e_cmp);
            chk("BestDist", int'(BestDist), bd[e_n]);
            chk("motionX", int'(motionX), bx[e_n]);
            chk("motionY", int'(motionY), by[e_n]);
        end
    end

    task automatic do_search(input int pulse_at);
        bit first;
        first = 1'b1;
        cyc = 0; n_en = 0; n_clr = 0;
        s1_first = -1; s1_last = -1; s2_last = -1;
        @(negedge clk);
        chk_en = 1'b0;
        @(posedge clk);
        build_model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 6000; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start  = 1'b0;
                chk_en = 1'b1;
            end
            if (i == pulse_at) start = 1'b1;
            else if (i == pulse_at + 1) start = 1'b0;
            if (pe_clear) n_clr++;
            if (pe_en) begin
                n_en++;
                if (n_clr == 16) begin
                    if (first) begin
                        s1_first = int'(AddressS1);
                        first = 1'b0;
                    end
                    s1_last = int'(AddressS1);
                    s2_last = int'(AddressS2);
                end
            end
            if (completed) begin
                cyc = i;
                break;
            end
        end
        chk("completed_seen", int'(completed), 1);
    endtask

    initial begin
        fill(200);
        sad[5*16+9] = 8'd17;
        build_model();

        // Reset held three cycles while start toggles.
        @(negedge clk);
        chk_en = 1'b1;
        repeat (3) begin
            start = ~start;
            @(negedge clk);
        end
        chk("rst_busy", int'(busy), 0);
        chk("rst_completed", int'(completed), 0);
        chk("rst_BestDist", int'(BestDist), 255);
        chk("rst_AddressS2", int'(AddressS2), 0);
        chk("rst_pe_clear", int'(pe_clear), 0);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Single best match, with a stray start at cycle 1000.
        do_search(1000);
        chk("t1_BestDist", int'(BestDist), 17);
        chk("t1_motionX", int'(motionX), 9);
        chk("t1_motionY", int'(motionY), 5);
        chk("t1_cycle", cyc, 4417);
        chk("t1_pe_en_cnt", n_en, 4096);
        chk("t1_pe_clear_cnt", n_clr, 16);
        chk("t1_s1_first_dy15", s1_first, 480);
        chk("t1_s1_last_dy15", s1_last, 975);
        chk("t1_s2_last_dy15", s2_last, 991);
        repeat (5) @(negedge clk);

        // Ties keep lowest dy, then lowest dx.
        fill(90);
        sad[3*16+12] = 8'd40;
        sad[3*16+2]  = 8'd40;
        sad[7*16+0]  = 8'd40;
        do_search(0);
        chk("t2_BestDist", int'(BestDist), 40);
        chk("t2_motionX", int'(motionX), 2);
        chk("t2_motionY", int'(motionY), 3);
        chk("t2_cycle", cyc, 4417);

        // All distances saturated: nothing beats the initial 255.
        fill(255);
        do_search(0);
        chk("t3_BestDist", int'(BestDist), 255);
        chk("t3_motionX", int'(motionX), 0);
        chk("t3_motionY", int'(motionY), 0);
        chk("t3_completed", int'(completed), 1);

        // Reset in the middle of dy=7, then a clean rerun.
        fill(200);
        sad[5*16+9] = 8'd17;
        @(negedge clk);
        chk_en = 1'b0;
        @(posedge clk);
        build_model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        chk_en = 1'b1;
        repeat (1980) @(negedge clk);
        chk("t4_pre_busy", int'(busy), 1);
        chk("t4_pre_BestDist", int'(BestDist), 17);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t4_busy", int'(busy), 0);
        chk("t4_BestDist", int'(BestDist), 255);
        chk("t4_motionY", int'(motionY), 0);
        chk("t4_pe_en", int'(pe_en), 0);
        chk("t4_AddressS1", int'(AddressS1), 0);
        repeat (4) @(negedge clk);
        do_search(0);
        chk("t5_BestDist", int'(BestDist), 17);
        chk("t5_motionX", int'(motionX), 9);
        chk("t5_motionY", int'(motionY), 5);
        chk("t5_cycle", cyc, 4417);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
